// File: rtl/n_serial_rx.sv
// n_serial_rx: Nintendo single-wire serial receiver; classifies low-pulse widths into bits and MSB-first bytes.
// Optional 3-sample majority glitch filter on the synchronized line: define N_SERIAL_RX_GLITCH_FILTER_EN.
module n_serial_rx #(
   parameter int US_CYCLES = 5,
   parameter int IDLE_US   = 6,
   parameter int CNT_WIDTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       busy,
   output logic [7:0] rx_data,
   output logic       rx_strobe,
   output logic       rx_stop,
   output logic       rx_error
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOW   = 2'd1,
      S_HIGH  = 2'd2,
      S_STUCK = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH:0] ONE_W     = (CNT_WIDTH + 1)'(1);
   localparam logic [CNT_WIDTH:0] TWO_W     = (CNT_WIDTH + 1)'(2);
   localparam logic [CNT_WIDTH:0] LIM_ONE   = (CNT_WIDTH + 1)'(2 * US_CYCLES);
   localparam logic [CNT_WIDTH:0] LIM_STUCK = (CNT_WIDTH + 1)'(4 * US_CYCLES);
   localparam logic [CNT_WIDTH:0] LIM_IDLE  = (CNT_WIDTH + 1)'(IDLE_US * US_CYCLES);

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      logic [CNT_WIDTH-1:0] r;
      if (v == {CNT_WIDTH{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   logic sync1_q, sync2_q, prev_q, cur_s;
   logic fall_s, rise_s;

   // two-flop synchronizer plus previous-sample register; idle level is high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= cur_s;
      end
   end

`ifdef N_SERIAL_RX_GLITCH_FILTER_EN
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic m1_q, m2_q, filt_q;

   // majority of three consecutive samples, registered, suppresses single-cycle pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m1_q   <= 1'b1;
         m2_q   <= 1'b1;
         filt_q <= 1'b1;
      end else begin
         m1_q   <= sync2_q;
         m2_q   <= m1_q;
         filt_q <= maj3(sync2_q, m1_q, m2_q);
      end
   end

   assign cur_s = filt_q;
`else
   assign cur_s = sync2_q;
`endif

   assign fall_s = prev_q & ~cur_s;
   assign rise_s = ~prev_q & cur_s;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [2:0]           bitcnt_q, bitcnt_d;
   logic [6:0]           shift_q, shift_d;
   logic [7:0]           rx_data_q, rx_data_d;
   logic                 rx_strobe_q, rx_strobe_d;
   logic                 rx_stop_q, rx_stop_d;
   logic                 rx_error_q, rx_error_d;
   logic                 busy_q, busy_d;
   logic [CNT_WIDTH:0]   len_s, run_s;
   logic                 bit_one_s;

   // cnt_q restarts at 0 on the edge cycle, so the run so far is cnt_q+1 before and cnt_q+2 including this cycle
   assign len_s     = {1'b0, cnt_q} + ONE_W;
   assign run_s     = {1'b0, cnt_q} + TWO_W;
   assign bit_one_s = (len_s < LIM_ONE);

   // state, counters and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= {CNT_WIDTH{1'b0}};
         bitcnt_q    <= 3'd0;
         shift_q     <= 7'd0;
         rx_data_q   <= 8'd0;
         rx_strobe_q <= 1'b0;
         rx_stop_q   <= 1'b0;
         rx_error_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bitcnt_q    <= bitcnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_strobe_q <= rx_strobe_d;
         rx_stop_q   <= rx_stop_d;
         rx_error_q  <= rx_error_d;
         busy_q      <= busy_d;
      end
   end

   // next-state and output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bitcnt_d    = bitcnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_strobe_d = 1'b0;
      rx_stop_d   = 1'b0;
      rx_error_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = {CNT_WIDTH{1'b0}};
            if (fall_s) begin
               state_d = S_LOW;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOW: begin
            if (rise_s) begin
               cnt_d   = {CNT_WIDTH{1'b0}};
               state_d = S_HIGH;
               if (bitcnt_q == 3'd7) begin
                  rx_data_d   = {shift_q, bit_one_s};
                  rx_strobe_d = 1'b1;
                  bitcnt_d    = 3'd0;
                  shift_d     = 7'd0;
               end else begin
                  shift_d  = {shift_q[5:0], bit_one_s};
                  bitcnt_d = bitcnt_q + 3'd1;
               end
            end else if (run_s >= LIM_STUCK) begin
               rx_error_d = 1'b1;
               bitcnt_d   = 3'd0;
               cnt_d      = {CNT_WIDTH{1'b0}};
               state_d    = S_STUCK;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         S_HIGH: begin
            // the idle timeout takes priority over a coincident falling edge
            if (run_s >= LIM_IDLE) begin
               case (bitcnt_q)
                  3'd0:    rx_stop_d  = 1'b0;
                  3'd1:    rx_stop_d  = 1'b1;
                  default: rx_error_d = 1'b1;
               endcase
               bitcnt_d = 3'd0;
               shift_d  = 7'd0;
               cnt_d    = {CNT_WIDTH{1'b0}};
               if (fall_s) begin
                  state_d = S_LOW;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (fall_s) begin
               cnt_d   = {CNT_WIDTH{1'b0}};
               state_d = S_LOW;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         S_STUCK: begin
            cnt_d = {CNT_WIDTH{1'b0}};
            if (cur_s) begin
               state_d = S_HIGH;
            end else begin
               state_d = S_STUCK;
            end
         end
         default: begin
            state_d  = S_IDLE;
            cnt_d    = {CNT_WIDTH{1'b0}};
            bitcnt_d = 3'd0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign busy      = busy_q;
   assign rx_data   = rx_data_q;
   assign rx_strobe = rx_strobe_q;
   assign rx_stop   = rx_stop_q;
   assign rx_error  = rx_error_q;

endmodule

// File: tb/tb_n_serial_rx.sv
// Directed self-checking bench for n_serial_rx (US_CYCLES=5, IDLE_US=6); honours N_SERIAL_RX_GLITCH_FILTER_EN.
module tb_n_serial_rx;

   localparam int IDLE_CYC = 30;
`ifdef N_SERIAL_RX_GLITCH_FILTER_EN
   localparam int LAT          = 4;
   localparam int GLITCH_STOPS = 0;
`else
   localparam int LAT          = 2;
   localparam int GLITCH_STOPS = 1;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       busy;
   logic [7:0] rx_data;
   logic       rx_strobe;
   logic       rx_stop;
   logic       rx_error;

   n_serial_rx #(.US_CYCLES(5), .IDLE_US(6), .CNT_WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .busy      (busy),
      .rx_data   (rx_data),
      .rx_strobe (rx_strobe),
      .rx_stop   (rx_stop),
      .rx_error  (rx_error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_strobe = 0;
   int n_stop = 0;
   int n_err = 0;
   int n_overlap = 0;
   int strobe_cyc = 0;
   int stop_cyc = 0;
   int err_cyc = 0;
   int last_rise = 0;
   logic busy_at_stop = 1'b1;
   logic [7:0] slog [0:63];

   always @(posedge clk) cyc <= cyc + 1;

   // event recorder; all checks are done in the test tasks
   always @(negedge clk) begin
      if (rx_strobe) begin
         slog[n_strobe % 64] = rx_data;
         n_strobe = n_strobe + 1;
         strobe_cyc = cyc;
      end
      if (rx_stop) begin
         n_stop = n_stop + 1;
         stop_cyc = cyc;
         busy_at_stop = busy;
      end
      if (rx_error) begin
         n_err = n_err + 1;
         err_cyc = cyc;
      end
      if (rx_strobe && rx_stop) n_overlap = n_overlap + 1;
   end

   task automatic drive(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      drive(1'b0, b ? 5 : 15);
      last_rise = cyc;
      drive(1'b1, b ? 15 : 5);
   endtask

   task automatic send_byte(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
   endtask

   task automatic send_stop(input int lo);
      drive(1'b0, lo);
      last_rise = cyc;
      drive(1'b1, 40);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
      total++; if (rx_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", rx_strobe); end
      total++; if (rx_stop !== 1'b0) begin bad++; $display("FAIL reset_stop: got %b want 0", rx_stop); end
      total++; if (rx_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", rx_error); end
      reset = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_console_stop();
      int s0, p0, e0;
      s0 = n_strobe; p0 = n_stop; e0 = n_err;
      send_byte(8'h5A);
      total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL b5a_strobes: got %0d want 1", n_strobe - s0); end
      total++; if (slog[s0 % 64] !== 8'h5A) begin bad++; $display("FAIL b5a_data: got %h want 5a", slog[s0 % 64]); end
      total++; if (strobe_cyc - last_rise !== LAT + 1) begin bad++; $display("FAIL b5a_strobe_lat: got %0d want %0d", strobe_cyc - last_rise, LAT + 1); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b5a_busy_mid: got %b want 1", busy); end
      send_stop(5);
      total++; if (n_stop - p0 !== 1) begin bad++; $display("FAIL b5a_stops: got %0d want 1", n_stop - p0); end
      total++; if (stop_cyc - last_rise !== LAT + IDLE_CYC) begin bad++; $display("FAIL b5a_stop_lat: got %0d want %0d", stop_cyc - last_rise, LAT + IDLE_CYC); end
      total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL b5a_errors: got %0d want 0", n_err - e0); end
      total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL b5a_data_hold: got %h want 5a", rx_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b5a_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int s0, p0, e0;
      s0 = n_strobe; p0 = n_stop; e0 = n_err;
      busy_at_stop = 1'b1;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_stop(10);
      total++; if (n_strobe - s0 !== 2) begin bad++; $display("FAIL b2b_strobes: got %0d want 2", n_strobe - s0); end
      total++; if (slog[s0 % 64] !== 8'h00) begin bad++; $display("FAIL b2b_first: got %h want 00", slog[s0 % 64]); end
      total++; if (slog[(s0 + 1) % 64] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %h want ff", slog[(s0 + 1) % 64]); end
      total++; if (n_stop - p0 !== 1) begin bad++; $display("FAIL b2b_stops: got %0d want 1", n_stop - p0); end
      total++; if (busy_at_stop !== 1'b0) begin bad++; $display("FAIL b2b_busy_at_stop: got %b want 0", busy_at_stop); end
      total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL b2b_errors: got %0d want 0", n_err - e0); end
   endtask

   task automatic test_partial_frame();
      int s0, p0, e0;
      s0 = n_strobe; p0 = n_stop; e0 = n_err;
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      drive(1'b1, 40);
      total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL part_strobes: got %0d want 0", n_strobe - s0); end
      total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL part_errors: got %0d want 1", n_err - e0); end
      total++; if (err_cyc - last_rise !== LAT + IDLE_CYC) begin bad++; $display("FAIL part_err_lat: got %0d want %0d", err_cyc - last_rise, LAT + IDLE_CYC); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL part_busy: got %b want 0", busy); end
      send_byte(8'hC3);
      send_stop(5);
      total++; if (slog[s0 % 64] !== 8'hC3) begin bad++; $display("FAIL part_c3_data: got %h want c3", slog[s0 % 64]); end
      total++; if (n_stop - p0 !== 1) begin bad++; $display("FAIL part_c3_stop: got %0d want 1", n_stop - p0); end
   endtask

   task automatic test_stuck_low();
      int s0, p0, e0, t0;
      s0 = n_strobe; p0 = n_stop; e0 = n_err;
      t0 = cyc;
      drive(1'b0, 25);
      total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL stuck_errors: got %0d want 1", n_err - e0); end
      total++; if (err_cyc - t0 !== LAT + 20) begin bad++; $display("FAIL stuck_err_lat: got %0d want %0d", err_cyc - t0, LAT + 20); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL stuck_busy_low: got %b want 1", busy); end
      drive(1'b1, 40);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stuck_busy_released: got %b want 0", busy); end
      send_byte(8'h81);
      send_stop(5);
      total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL stuck_81_strobes: got %0d want 1", n_strobe - s0); end
      total++; if (slog[s0 % 64] !== 8'h81) begin bad++; $display("FAIL stuck_81_data: got %h want 81", slog[s0 % 64]); end
      total++; if (n_stop - p0 !== 1) begin bad++; $display("FAIL stuck_81_stop: got %0d want 1", n_stop - p0); end
      total++; if (n_err - e0 !== 1) begin bad++; $display("FAIL stuck_total_errors: got %0d want 1", n_err - e0); end
   endtask

   task automatic test_reset_mid_frame();
      int s0, p0, e0;
      s0 = n_strobe; p0 = n_stop; e0 = n_err;
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      reset = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
      total++; if (rx_strobe !== 1'b0) begin bad++; $display("FAIL rstmid_strobe: got %b want 0", rx_strobe); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 5);
      send_byte(8'h12);
      send_stop(5);
      total++; if (n_strobe - s0 !== 1) begin bad++; $display("FAIL rstmid_strobes: got %0d want 1", n_strobe - s0); end
      total++; if (slog[s0 % 64] !== 8'h12) begin bad++; $display("FAIL rstmid_12_data: got %h want 12", slog[s0 % 64]); end
      total++; if (n_stop - p0 !== 1) begin bad++; $display("FAIL rstmid_stops: got %0d want 1", n_stop - p0); end
      total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL rstmid_errors: got %0d want 0", n_err - e0); end
   endtask

   task automatic test_glitch();
      int s0, p0, e0;
      s0 = n_strobe; p0 = n_stop; e0 = n_err;
      drive(1'b1, 10);
      drive(1'b0, 1);
      drive(1'b1, 45);
      total++; if (n_stop - p0 !== GLITCH_STOPS) begin bad++; $display("FAIL glitch_stops: got %0d want %0d", n_stop - p0, GLITCH_STOPS); end
      total++; if (n_strobe - s0 !== 0) begin bad++; $display("FAIL glitch_strobes: got %0d want 0", n_strobe - s0); end
      total++; if (n_err - e0 !== 0) begin bad++; $display("FAIL glitch_errors: got %0d want 0", n_err - e0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
      total++; if (n_overlap !== 0) begin bad++; $display("FAIL strobe_stop_overlap: got %0d want 0", n_overlap); end
   endtask

   initial begin
      test_reset();
      test_console_stop();
      test_back_to_back();
      test_partial_frame();
      test_stuck_low();
      test_reset_mid_frame();
      test_glitch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
